// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM encoding for the SPI control register bank.
// Address map of the five control registers and the default bank depth.
// FSM state type used by spi_reg_bank (IDLE=0, DECODE=1, WAIT_LOW=2).
package spi_reg_pkg;

    localparam int NUM_REGS_DEFAULT = 5;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECODE   = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

endpackage

// File: rtl/spi_reg_bank_sat_counter.sv
// Event counter that either wraps or saturates at all-ones (sat_en selects).
// Latency: count reflects an inc pulse one clock after it is sampled.
// Backpressure: none; one increment per asserted cycle.
// Ports: clk, rst (async, active-high), inc, sat_en, count[WIDTH-1:0].
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             sat_en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !(sat_en && (&count))) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// Commits decoded SPI write frames (once per frame) into a 5x8 control bank driving the PWM peripheral.
// Latency: frame rise sampled at E0, register/outputs/counters/wr_strobe update at E1.
// Backpressure: none; a frame whose rise lands while busy is dropped and counted in err_cnt.
// Ports: clk, rst (async active-high), read_write/addr/data/valid (frame in), en_out, en_pwm,
//        pwm_duty, wr_strobe, wr_cnt, err_cnt; apply only when REG_SHADOW_EN is defined,
//        in which case commits land in a shadow bank and apply copies it to the outputs.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    input  logic                valid,
`ifdef REG_SHADOW_EN
    input  logic                apply,
`endif
    output logic [2*DATA_W-1:0] en_out,
    output logic [2*DATA_W-1:0] en_pwm,
    output logic [DATA_W-1:0]   pwm_duty,
    output logic                wr_strobe,
    output logic [CNT_W-1:0]    wr_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    state_t              state, state_nxt;
    logic                valid_q;
    logic                rise;
    logic                hold_rw;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_data;
    logic                latch;
    logic                commit;
    logic                bad_wr;
    logic                overrun;
    logic                addr_ok;
    logic [DATA_W-1:0]   bank [NUM_REGS];
    logic [DATA_W-1:0]   vis  [NUM_REGS];

    // valid_q resets high so a level already asserted at reset release is not a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b1;
        else     valid_q <= valid;
    end

    assign rise    = valid & ~valid_q;
    // Full-width compare: high address bits never alias onto real registers.
    assign addr_ok = (hold_addr < ADDR_W'(NUM_REGS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        commit    = 1'b0;
        bad_wr    = 1'b0;
        overrun   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    latch     = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (hold_rw) begin
                    if (addr_ok) commit = 1'b1;
                    else         bad_wr = 1'b1;
                end
                overrun   = rise;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                // A fresh rise here means the previous frame's valid dropped and came
                // back before we returned to IDLE: drop it rather than commit twice.
                overrun = rise;
                if (!valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_rw   <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
        end else if (latch) begin
            hold_rw   <= read_write;
            hold_addr <= addr;
            hold_data <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (hold_addr == ADDR_W'(i)) bank[i] <= hold_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_strobe <= 1'b0;
        else     wr_strobe <= commit;
    end

`ifdef REG_SHADOW_EN
    // bank is the shadow copy; outputs only move on apply. A commit on the same
    // edge as apply is not visible until the next apply (bank is read pre-edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) vis[i] <= '0;
        end else if (apply) begin
            for (int i = 0; i < NUM_REGS; i++) vis[i] <= bank[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) vis[i] = bank[i];
    end
`endif

    assign en_out   = {vis[ADDR_EN_OUT_HI], vis[ADDR_EN_OUT_LO]};
    assign en_pwm   = {vis[ADDR_EN_PWM_HI], vis[ADDR_EN_PWM_LO]};
    assign pwm_duty = vis[ADDR_DUTY];

    sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (commit),
        .sat_en (1'b0),
        .count  (wr_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (bad_wr | overrun),
        .sat_en (1'b1),
        .count  (err_cnt)
    );

endmodule
